// File: rtl/sprite_io_pkg.sv
// Shared constants and types for the processor-to-VGA sprite coordinate path.
package sprite_io_pkg;

    localparam int unsigned NUM_ENTRIES = 100;
    localparam int unsigned X_BASE      = 300;
    localparam int unsigned Y_BASE      = 400;

    localparam int unsigned ADDR_GAME_DONE = 1;
    localparam int unsigned ADDR_CLEAR     = 5;
    localparam int unsigned ADDR_COMMIT    = 6;
    localparam int unsigned ADDR_STATUS    = 7;

    localparam logic [31:0] CLEAR_VAL = 32'hFFFF_FFFF;
    localparam logic [6:0]  LAST_IDX  = 7'(NUM_ENTRIES - 1);

    typedef enum logic [1:0] {
        CLEAR_ALL = 2'd0,
        IDLE      = 2'd1,
        CLEAR     = 2'd2,
        WAIT_SWAP = 2'd3
    } sweep_state_e;

endpackage

// File: rtl/sprite_coord_bank.sv
// Double-buffered coordinate storage: two banks of x/y slots, one write port,
// one registered read port on the selected (front) bank.
module sprite_coord_bank
    import sprite_io_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        we,
    input  logic        all_banks,
    input  logic        wr_bank,
    input  logic [1:0]  wr_axis,
    input  logic [6:0]  wr_idx,
    input  logic [31:0] wr_data,
    input  logic        rd_bank,
    input  logic [6:0]  rd_idx,
    output logic [31:0] rd_x,
    output logic [31:0] rd_y
);

    logic [31:0] mem_x0 [NUM_ENTRIES];
    logic [31:0] mem_y0 [NUM_ENTRIES];
    logic [31:0] mem_x1 [NUM_ENTRIES];
    logic [31:0] mem_y1 [NUM_ENTRIES];

    logic sel0;
    logic sel1;

    assign sel0 = we && (all_banks || !wr_bank);
    assign sel1 = we && (all_banks ||  wr_bank);

    always_ff @(posedge clock) begin
        if (sel0 && wr_axis[0]) mem_x0[wr_idx] <= wr_data;
        if (sel0 && wr_axis[1]) mem_y0[wr_idx] <= wr_data;
        if (sel1 && wr_axis[0]) mem_x1[wr_idx] <= wr_data;
        if (sel1 && wr_axis[1]) mem_y1[wr_idx] <= wr_data;
    end

    always_ff @(posedge clock) begin
        if (reset || rd_idx > LAST_IDX) begin
            rd_x <= CLEAR_VAL;
            rd_y <= CLEAR_VAL;
        end else begin
            rd_x <= rd_bank ? mem_x1[rd_idx] : mem_x0[rd_idx];
            rd_y <= rd_bank ? mem_y1[rd_idx] : mem_y0[rd_idx];
        end
    end

endmodule

// File: rtl/sprite_coord_ctrl.sv
// Sprite coordinate controller: processor write decode, bank swap on frame
// boundaries, clear sweeps, sticky game-done flag and pollable status word.
module sprite_coord_ctrl
    import sprite_io_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        mwe,
    input  logic [11:0] mem_addr,
    input  logic [31:0] mem_data_in,
    input  logic        frame_start,
    input  logic [6:0]  rd_idx,
    output logic [31:0] rd_x,
    output logic [31:0] rd_y,
    output logic [31:0] status,
    output logic        status_hit,
    output logic        game_done
);

    localparam logic [11:0] X_LO   = 12'(X_BASE);
    localparam logic [11:0] X_HI   = 12'(X_BASE + NUM_ENTRIES - 1);
    localparam logic [11:0] Y_LO   = 12'(Y_BASE);
    localparam logic [11:0] Y_HI   = 12'(Y_BASE + NUM_ENTRIES - 1);
    localparam logic [11:0] A_GD   = 12'(ADDR_GAME_DONE);
    localparam logic [11:0] A_CLR  = 12'(ADDR_CLEAR);
    localparam logic [11:0] A_CMT  = 12'(ADDR_COMMIT);
    localparam logic [11:0] A_STAT = 12'(ADDR_STATUS);

    sweep_state_e state;
    logic [6:0]   ptr;
    logic         front;
    logic         swap_pending;
    logic         drop_flag;

    logic         x_hit, y_hit, coord_wr;
    logic         clr_req, cmt_req, drop_clr, gd_set;
    logic [6:0]   coord_idx;
    logic         busy, sweep_last;

    logic         bk_we, bk_all;
    logic [1:0]   bk_axis;
    logic [6:0]   bk_idx;
    logic [31:0]  bk_data;

    assign x_hit     = mwe && mem_addr >= X_LO && mem_addr <= X_HI;
    assign y_hit     = mwe && mem_addr >= Y_LO && mem_addr <= Y_HI;
    assign coord_wr  = x_hit || y_hit;
    assign coord_idx = x_hit ? 7'(mem_addr - X_LO) : 7'(mem_addr - Y_LO);
    assign clr_req   = mwe && mem_addr == A_CLR;
    assign cmt_req   = mwe && mem_addr == A_CMT;
    assign drop_clr  = mwe && mem_addr == A_STAT;
    assign gd_set    = mwe && mem_addr == A_GD && mem_data_in == 32'd1;

    assign busy       = (state == CLEAR_ALL) || (state == CLEAR);
    assign sweep_last = ptr == LAST_IDX;

    assign status     = {29'b0, drop_flag, swap_pending, busy};
    assign status_hit = mem_addr == A_STAT;

    // The sweep owns the write port while busy; processor coordinate writes are dropped then.
    always_comb begin
        bk_we   = 1'b0;
        bk_all  = 1'b0;
        bk_axis = 2'b00;
        bk_idx  = '0;
        bk_data = CLEAR_VAL;
        if (!reset) begin
            if (busy) begin
                bk_we   = 1'b1;
                bk_all  = state == CLEAR_ALL;
                bk_axis = 2'b11;
                bk_idx  = ptr;
            end else if (coord_wr) begin
                bk_we   = 1'b1;
                bk_axis = {y_hit, x_hit};
                bk_idx  = coord_idx;
                bk_data = mem_data_in;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= CLEAR_ALL;
            ptr          <= '0;
            front        <= 1'b0;
            swap_pending <= 1'b0;
            drop_flag    <= 1'b0;
            game_done    <= 1'b0;
        end else begin
            if (gd_set) game_done <= 1'b1;

            if (coord_wr && busy) drop_flag <= 1'b1;
            else if (drop_clr)    drop_flag <= 1'b0;

            case (state)
                CLEAR_ALL, CLEAR: begin
                    if (cmt_req) swap_pending <= 1'b1;
                    if (clr_req) begin
                        ptr <= '0;
                    end else if (sweep_last) begin
                        ptr   <= '0;
                        state <= (swap_pending || cmt_req) ? WAIT_SWAP : IDLE;
                    end else begin
                        ptr <= ptr + 7'd1;
                    end
                end
                IDLE: begin
                    if (clr_req) begin
                        ptr   <= '0;
                        state <= CLEAR;
                    end else if (cmt_req) begin
                        swap_pending <= 1'b1;
                        state        <= WAIT_SWAP;
                    end
                end
                WAIT_SWAP: begin
                    if (frame_start) begin
                        front        <= ~front;
                        swap_pending <= 1'b0;
                        ptr          <= '0;
                        state        <= CLEAR;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sprite_coord_bank u_bank (
        .clock     (clock),
        .reset     (reset),
        .we        (bk_we),
        .all_banks (bk_all),
        .wr_bank   (~front),
        .wr_axis   (bk_axis),
        .wr_idx    (bk_idx),
        .wr_data   (bk_data),
        .rd_bank   (front),
        .rd_idx    (rd_idx),
        .rd_x      (rd_x),
        .rd_y      (rd_y)
    );

endmodule

// File: tb/tb_sprite_coord_ctrl.sv
// Self-checking bench for sprite_coord_ctrl: directed vectors plus randomized
// traffic against a slot-array reference model.
module tb_sprite_coord_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        mwe;
    logic [11:0] mem_addr;
    logic [31:0] mem_data_in;
    logic        frame_start;
    logic [6:0]  rd_idx;
    logic [31:0] rd_x, rd_y, status;
    logic        status_hit, game_done;

    int checks = 0;
    int errors = 0;

    sprite_coord_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .mwe         (mwe),
        .mem_addr    (mem_addr),
        .mem_data_in (mem_data_in),
        .frame_start (frame_start),
        .rd_idx      (rd_idx),
        .rd_x        (rd_x),
        .rd_y        (rd_y),
        .status      (status),
        .status_hit  (status_hit),
        .game_done   (game_done)
    );

    always #20 clock = ~clock;

    localparam int N = 100;
    localparam logic [31:0] EMPTY = 32'hFFFF_FFFF;

    // Reference model: slots[bank][axis][idx], plus the remaining sweep length.
    logic [31:0] m_mem   [2][2][N];
    bit          m_known [2][2][N];
    int          m_front;
    int          m_sweep;
    bit          m_all, m_pend, m_drop, m_gd;
    bit          model_live = 0;
    logic [31:0] exp_x, exp_y;
    bit          exp_known;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit m, input logic [11:0] a,
                                input logic [31:0] d, input bit fs, input logic [6:0] ri);
        int  ia;
        bit  busy, waiting;
        ia = int'(a);
        if (r) begin
            m_front = 0; m_pend = 0; m_drop = 0; m_gd = 0;
            m_sweep = N; m_all = 1;
            exp_x = EMPTY; exp_y = EMPTY; exp_known = 1;
            return;
        end
        busy    = m_sweep > 0;
        waiting = !busy && m_pend;
        if (int'(ri) < N) begin
            exp_x     = m_mem[m_front][0][ri];
            exp_y     = m_mem[m_front][1][ri];
            exp_known = m_known[m_front][0][ri] && m_known[m_front][1][ri];
        end else begin
            exp_x = EMPTY; exp_y = EMPTY; exp_known = 1;
        end
        if (busy) begin
            int slot;
            slot = N - m_sweep;
            for (int b = 0; b < 2; b++)
                if (m_all || b != m_front)
                    for (int ax = 0; ax < 2; ax++) begin
                        m_mem[b][ax][slot]   = EMPTY;
                        m_known[b][ax][slot] = 1;
                    end
            m_sweep--;
        end
        if (m && ia >= 300 && ia < 500) begin
            if (busy) m_drop = 1;
            else begin
                int ax, idx;
                ax  = (ia >= 400) ? 1 : 0;
                idx = ia - (ax == 1 ? 400 : 300);
                m_mem[1 - m_front][ax][idx]   = d;
                m_known[1 - m_front][ax][idx] = 1;
            end
        end
        if (m && ia == 7) m_drop = 0;
        if (m && ia == 1 && d == 32'd1) m_gd = 1;
        if (m && ia == 5) begin
            if (busy) m_sweep = N;
            else if (!m_pend) begin m_sweep = N; m_all = 0; end
        end
        if (m && ia == 6) m_pend = 1;
        if (waiting && fs) begin
            m_front = 1 - m_front;
            m_pend  = 0;
            m_sweep = N;
            m_all   = 0;
        end
    endtask

    task automatic step(input bit r, input bit m, input logic [11:0] a, input logic [31:0] d,
                        input bit fs, input logic [6:0] ri,
                        output logic [31:0] st_s, output logic [31:0] rx_s, output logic [31:0] ry_s);
        logic [31:0] e_st;
        reset = r; mwe = m; mem_addr = a; mem_data_in = d; frame_start = fs; rd_idx = ri;
        @(negedge clock);
        st_s = status;
        if (model_live) begin
            e_st = '0;
            e_st[0] = m_sweep != 0;
            e_st[1] = m_pend;
            e_st[2] = m_drop;
            chk("status", status, e_st);
            chk("status_hit", 32'(status_hit), 32'(a == 12'd7));
        end
        model_update(r, m, a, d, fs, ri);
        @(posedge clock);
        #1;
        rx_s = rd_x;
        ry_s = rd_y;
        if (exp_known) begin
            chk("rd_x", rd_x, exp_x);
            chk("rd_y", rd_y, exp_y);
        end
        chk("game_done", 32'(game_done), 32'(m_gd));
        model_live = 1;
    endtask

    typedef struct {
        bit          m;
        logic [11:0] a;
        logic [31:0] d;
        bit          fs;
        logic [31:0] e_status;
        logic [31:0] e_x;
        logic [31:0] e_y;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [31:0] st, rx, ry;
        int          busy_n;

        vecs[0] = '{1, 12'd300, 32'd12, 0, 32'h0, EMPTY, EMPTY};
        vecs[1] = '{1, 12'd400, 32'd34, 0, 32'h0, EMPTY, EMPTY};
        vecs[2] = '{1, 12'd6,   32'd0,  0, 32'h0, EMPTY, EMPTY};
        vecs[3] = '{0, 12'd0,   32'd0,  0, 32'h2, EMPTY, EMPTY};
        vecs[4] = '{0, 12'd0,   32'd0,  1, 32'h2, EMPTY, EMPTY};
        vecs[5] = '{0, 12'd0,   32'd0,  0, 32'h1, 32'd12, 32'd34};
        vecs[6] = '{1, 12'd305, 32'd9,  0, 32'h1, 32'd12, 32'd34};
        vecs[7] = '{0, 12'd0,   32'd0,  0, 32'h5, 32'd12, 32'd34};
        vecs[8] = '{1, 12'd7,   32'd0,  0, 32'h5, 32'd12, 32'd34};
        vecs[9] = '{0, 12'd0,   32'd0,  0, 32'h1, 32'd12, 32'd34};

        for (int i = 0; i < 3; i++) step(1, 0, 12'd0, 32'd0, 0, 7'd0, st, rx, ry);
        chk("reset_rd_x", rx, EMPTY);
        chk("reset_game_done", 32'(game_done), 32'd0);

        busy_n = 0;
        for (int i = 0; i < 200; i++) begin
            step(0, 0, 12'd0, 32'd0, 0, 7'd0, st, rx, ry);
            if (st[0]) busy_n++;
            else break;
        end
        chk("init_busy_cycles", busy_n, 32'd100);

        for (int i = 0; i < 128; i++) begin
            step(0, 0, 12'd0, 32'd0, 0, 7'(i), st, rx, ry);
            chk("cleared_x", rx, EMPTY);
            chk("cleared_y", ry, EMPTY);
        end

        for (int i = 0; i < 10; i++) begin
            step(0, vecs[i].m, vecs[i].a, vecs[i].d, vecs[i].fs, 7'd0, st, rx, ry);
            chk($sformatf("vec%0d_status", i), st, vecs[i].e_status);
            chk($sformatf("vec%0d_x", i), rx, vecs[i].e_x);
            chk($sformatf("vec%0d_y", i), ry, vecs[i].e_y);
        end

        busy_n = 5;
        for (int i = 0; i < 200; i++) begin
            step(0, 0, 12'd0, 32'd0, 0, 7'd0, st, rx, ry);
            if (st[0]) busy_n++;
            else break;
        end
        chk("swap_busy_cycles", busy_n, 32'd100);

        step(0, 1, 12'd350, 32'd7, 0, 7'd50, st, rx, ry);
        step(0, 0, 12'd0, 32'd0, 1, 7'd50, st, rx, ry);
        step(0, 0, 12'd0, 32'd0, 0, 7'd50, st, rx, ry);
        chk("no_commit_no_swap", rx, EMPTY);

        step(0, 1, 12'd6, 32'd0, 1, 7'd50, st, rx, ry);
        chk("same_cycle_pre", st, 32'h0);
        step(0, 0, 12'd0, 32'd0, 0, 7'd50, st, rx, ry);
        chk("same_cycle_pending", st, 32'h2);
        chk("same_cycle_no_swap", rx, EMPTY);
        step(0, 0, 12'd0, 32'd0, 1, 7'd50, st, rx, ry);
        chk("pending_held", st, 32'h2);
        step(0, 0, 12'd0, 32'd0, 0, 7'd50, st, rx, ry);
        chk("swapped_busy", st, 32'h1);
        chk("swapped_x", rx, 32'd7);
        chk("swapped_y", ry, EMPTY);

        step(0, 1, 12'd1, 32'd2, 0, 7'd0, st, rx, ry);
        chk("gd_other_value", 32'(game_done), 32'd0);
        step(0, 1, 12'd1, 32'd1, 0, 7'd0, st, rx, ry);
        chk("gd_set", 32'(game_done), 32'd1);
        step(0, 1, 12'd1, 32'd0, 0, 7'd0, st, rx, ry);
        chk("gd_sticky", 32'(game_done), 32'd1);

        for (int i = 0; i < 3000; i++) begin
            int          sel;
            bit          r, m, fs;
            logic [11:0] a;
            logic [31:0] d;
            r   = $urandom_range(0, 499) == 0;
            m   = $urandom_range(0, 1) == 1;
            fs  = $urandom_range(0, 19) == 0;
            sel = $urandom_range(0, 99);
            if (sel < 35)      a = 12'(300 + $urandom_range(0, 99));
            else if (sel < 70) a = 12'(400 + $urandom_range(0, 99));
            else if (sel < 72) a = 12'd5;
            else if (sel < 77) a = 12'd6;
            else if (sel < 80) a = 12'd1;
            else if (sel < 84) a = 12'd7;
            else               a = 12'($urandom);
            d = ($urandom_range(0, 3) == 0) ? 32'd1 : $urandom;
            step(r, m, a, d, fs, 7'($urandom_range(0, 127)), st, rx, ry);
        end

        step(1, 0, 12'd0, 32'd0, 0, 7'd0, st, rx, ry);
        chk("final_reset_gd", 32'(game_done), 32'd0);
        chk("final_reset_rd", rx, EMPTY);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
